// File: rtl/canvas_i2c_pkg.sv
// canvas_i2c_pkg: shared FSM state type and framing constants for the canvas I2C reader
package canvas_i2c_pkg;
  typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, READ, MACK, STOP, DONE} state_t;
  localparam logic [6:0] CANVAS_ADDR = 7'b1100100;
  localparam int QUARTERS_PER_BIT = 4;
  localparam int BYTES_PER_READ = 3;
endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick: one-cycle tick every CLK_DIV clocks while enabled, counter held at zero otherwise
module i2c_quarter_tick #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  logic [7:0] cnt;
  assign tick = en && cnt == 8'(CLK_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (!en || tick) ? '0 : cnt + 8'd1;
endmodule

// File: rtl/canvas_i2c_reader.sv
// canvas_i2c_reader: I2C master reading a 3-byte x/y/status record from the canvas slave
module canvas_i2c_reader
  import canvas_i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = CANVAS_ADDR,
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic [7:0] x_pos,
  output logic [7:0] y_pos,
  output logic [7:0] status,
  output logic       valid,
  output logic       busy,
  output logic       nack_err
);
  localparam logic [1:0] Q_LAST = 2'(QUARTERS_PER_BIT - 1);
  localparam logic [1:0] B_LAST = 2'(BYTES_PER_READ - 1);
  localparam logic [7:0] ADDR_RD = {I2C_ADDR, 1'b1};
  state_t state, state_nx;
  logic [1:0] sync, q, byte_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] sh, b0, b1;
  logic smp, tick, en, slot_end, sample, bit_scl;
  assign en = state != IDLE && state != DONE;
  assign busy = state != IDLE;
  assign valid = state == DONE && !nack_err;
  assign slot_end = tick && q == Q_LAST;
  assign sample = tick && q == 2'd2;
  assign bit_scl = q == 2'd0 || q == 2'd3;
  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .tick(tick)
  );
  // Line drives are pure decodes of state/quarter so reset releases them at once
  always_comb begin
    state_nx = state;
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state)
      IDLE: state_nx = start ? START : IDLE;
      START: begin
        scl_oe = q == 2'd3;
        sda_oe = q[1];
        state_nx = slot_end ? ADDR : START;
      end
      ADDR: begin
        scl_oe = bit_scl;
        sda_oe = !ADDR_RD[~bit_cnt];
        state_nx = (slot_end && bit_cnt == 3'd7) ? ADDR_ACK : ADDR;
      end
      ADDR_ACK: begin
        scl_oe = bit_scl;
        state_nx = slot_end ? (smp ? STOP : READ) : ADDR_ACK;
      end
      READ: begin
        scl_oe = bit_scl;
        state_nx = (slot_end && bit_cnt == 3'd7) ? MACK : READ;
      end
      MACK: begin
        scl_oe = bit_scl;
        sda_oe = byte_cnt != B_LAST;
        state_nx = slot_end ? (byte_cnt == B_LAST ? STOP : READ) : MACK;
      end
      STOP: begin
        scl_oe = q == 2'd0;
        sda_oe = !q[1];
        state_nx = slot_end ? DONE : STOP;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sync <= 2'b11;
      q <= '0;
      bit_cnt <= '0;
      byte_cnt <= '0;
      smp <= 1'b1;
      sh <= '0;
      b0 <= '0;
      b1 <= '0;
      nack_err <= 1'b0;
      x_pos <= '0;
      y_pos <= '0;
      status <= '0;
    end else begin
      state <= state_nx;
      sync <= {sync[0], sda_in};
      if (tick) q <= q + 2'd1;
      if (sample) smp <= sync[1];
      if (sample && state == READ) sh <= {sh[6:0], sync[1]};
      if (slot_end && (state == ADDR || state == READ)) bit_cnt <= bit_cnt + 3'd1;
      if (state == IDLE) byte_cnt <= '0;
      else if (slot_end && state == MACK) byte_cnt <= byte_cnt + 2'd1;
      if (slot_end && state == READ && bit_cnt == 3'd7 && byte_cnt == 2'd0) b0 <= sh;
      if (slot_end && state == READ && bit_cnt == 3'd7 && byte_cnt == 2'd1) b1 <= sh;
      if (state == IDLE && start) nack_err <= 1'b0;
      else if (slot_end && state == ADDR_ACK && smp) nack_err <= 1'b1;
      // The third byte is still in the shifter when the record is published
      if (slot_end && state == STOP && !nack_err) begin
        x_pos <= b0;
        y_pos <= b1;
        status <= sh;
      end
    end
endmodule
